// File: rtl/pll_reset_sequencer.sv
// Post-lock reset sequencer: synchronizes PLL lock, releases the core then the peripheral
// reset domain, and produces a half-rate clock enable while the core is out of reset.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_LOCK | waiting for synchronized lock, everything held in reset
// SETTLE    | lock seen, counting SETTLE_CYCLES before any release
// REL_CORE  | core released, counting STAGE_GAP before peripheral release
// RUN       | both domains released, ready asserted
// HOLD      | soft reset, both domains held for HOLD_CYCLES
module pll_reset_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned STAGE_GAP     = 16,
    parameter int unsigned HOLD_CYCLES   = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_lock,
    input  logic soft_reset,
    output logic core_reset_n,
    output logic periph_reset_n,
    output logic clk_en_half,
    output logic ready
);

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD    = 16'(STAGE_GAP - 1);
    localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        REL_CORE  = 3'd2,
        RUN       = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        lock_meta;
    logic        lock_s;
    logic        core_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (lock_s) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = REL_CORE;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            REL_CORE: begin
                if (cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            RUN: begin
                if (soft_reset) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = REL_CORE;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
        // Losing lock beats soft reset and any counter expiry.
        if (state != WAIT_LOCK && !lock_s) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
        end
    end

    assign core_nxt = (state_nxt == REL_CORE) || (state_nxt == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= WAIT_LOCK;
            cnt            <= '0;
            core_reset_n   <= 1'b0;
            periph_reset_n <= 1'b0;
            clk_en_half    <= 1'b0;
            ready          <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            core_reset_n   <= core_nxt;
            periph_reset_n <= (state_nxt == RUN);
            ready          <= (state_nxt == RUN);
            // Enable phase restarts at 1 on every core release.
            if (!core_nxt) begin
                clk_en_half <= 1'b0;
            end else if (!core_reset_n) begin
                clk_en_half <= 1'b1;
            end else begin
                clk_en_half <= ~clk_en_half;
            end
        end
    end

endmodule
